// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding and widths shared with the load/store buffers
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ST_WR, S_LD_RD, S_CDB} state_t;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_XLEN = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr and wrapping
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] hi, pick;
  always_comb begin
    hi = req & ~((N'(1) << ptr) - N'(1));
    pick = |hi ? hi : req;
    gnt = pick & (~pick + N'(1));
  end
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: sequences single-port data memory for load/store slots, broadcasts loads on CDB
module mem_access_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_LD = 2,
  parameter int NUM_ST = 2,
  parameter int TAG_W = DEF_TAG_W,
  parameter int XLEN = DEF_XLEN,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_LD-1:0]       ld_req,
  input  logic [NUM_LD*TAG_W-1:0] ld_tag,
  input  logic [NUM_LD*XLEN-1:0]  ld_addr,
  output logic [NUM_LD-1:0]       ld_ack,
  input  logic [NUM_ST-1:0]       st_req,
  input  logic [NUM_ST*XLEN-1:0]  st_addr,
  input  logic [NUM_ST*XLEN-1:0]  st_data,
  output logic [NUM_ST-1:0]       st_ack,
  output logic                    mem_we,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic                    cdb_req,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]         cdb_data,
  input  logic                    cdb_grant,
  output logic                    busy
);
  localparam int PW = NUM_LD > 1 ? $clog2(NUM_LD) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t state, state_d;
  logic [PW-1:0] rr_ptr, rr_ptr_d, ld_next;
  logic [SW-1:0] starve_cnt, starve_d;
  logic [1:0] lat_cnt, lat_d;
  logic [TAG_W-1:0] tag_q, tag_d, cdb_tag_d, ld_sel_tag;
  logic [NUM_LD-1:0] ld_gnt, ld_ack_d;
  logic [NUM_ST-1:0] st_gnt, st_ack_d;
  logic mem_we_d, cdb_req_d, ld_any, st_any, ld_win;
  logic [XLEN-1:0] mem_addr_d, mem_wdata_d, cdb_data_d, ld_sel_addr, st_sel_addr, st_sel_data;

  rr_arbiter #(.N(NUM_LD), .PW(PW)) u_rr (.req(ld_req), .ptr(rr_ptr), .gnt(ld_gnt));

  assign ld_any = |ld_req;
  assign st_any = |st_req;
  assign ld_win = ld_any && (starve_cnt == SW'(STARVE_MAX) || !st_any);
  assign busy = state != S_IDLE;

  always_comb begin
    st_gnt = st_req & (~st_req + NUM_ST'(1));
    ld_sel_addr = '0;
    ld_sel_tag = '0;
    ld_next = '0;
    st_sel_addr = '0;
    st_sel_data = '0;
    for (int i = 0; i < NUM_LD; i++)
      if (ld_gnt[i]) begin
        ld_sel_addr = ld_addr[i*XLEN +: XLEN];
        ld_sel_tag = ld_tag[i*TAG_W +: TAG_W];
        ld_next = PW'((i + 1) % NUM_LD);
      end
    for (int i = 0; i < NUM_ST; i++)
      if (st_gnt[i]) begin
        st_sel_addr = st_addr[i*XLEN +: XLEN];
        st_sel_data = st_data[i*XLEN +: XLEN];
      end
  end

  always_comb begin
    state_d = state;
    ld_ack_d = '0;
    st_ack_d = '0;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr;
    mem_wdata_d = mem_wdata;
    cdb_req_d = 1'b0;
    cdb_tag_d = cdb_tag;
    cdb_data_d = cdb_data;
    rr_ptr_d = rr_ptr;
    lat_d = lat_cnt;
    tag_d = tag_q;
    starve_d = ld_any ? starve_cnt : '0;
    case (state)
      S_IDLE:
        if (ld_win) begin
          state_d = S_LD_RD;
          ld_ack_d = ld_gnt;
          mem_addr_d = ld_sel_addr;
          tag_d = ld_sel_tag;
          rr_ptr_d = ld_next;
          starve_d = '0;
          lat_d = '0;
        end else if (st_any) begin
          state_d = S_ST_WR;
          st_ack_d = st_gnt;
          mem_we_d = 1'b1;
          mem_addr_d = st_sel_addr;
          mem_wdata_d = st_sel_data;
          starve_d = !ld_any ? '0 : starve_cnt == SW'(STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
        end
      S_ST_WR: state_d = S_IDLE;
      S_LD_RD:
        if (lat_cnt == 2'(MEM_LAT - 1)) begin
          state_d = S_CDB;
          cdb_req_d = 1'b1;
          cdb_tag_d = tag_q;
          cdb_data_d = mem_rdata;
        end else lat_d = lat_cnt + 2'd1;
      default: begin
        state_d = cdb_grant ? S_IDLE : S_CDB;
        cdb_req_d = !cdb_grant;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      starve_cnt <= '0;
      lat_cnt <= '0;
      tag_q <= '0;
      ld_ack <= '0;
      st_ack <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cdb_req <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_ptr_d;
      starve_cnt <= starve_d;
      lat_cnt <= lat_d;
      tag_q <= tag_d;
      ld_ack <= ld_ack_d;
      st_ack <= st_ack_d;
      mem_we <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cdb_req <= cdb_req_d;
      cdb_tag <= cdb_tag_d;
      cdb_data <= cdb_data_d;
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed tests against a transaction-timeline model of the arbiter
module tb_mem_access_arbiter;
  localparam int NLD = 2, NST = 2, TW = 4, XL = 32, LAT = 1, SMAX = 4;
  logic clk = 0, rst_n = 0, cdb_grant = 1;
  logic [NLD-1:0] ld_req = '0, ld_ack, ld_os;
  logic [NST-1:0] st_req = '0, st_ack, st_os;
  logic [TW-1:0] lt[NLD];
  logic [XL-1:0] la[NLD], sa[NST], sd[NST];
  logic mem_we, cdb_req, busy;
  logic [XL-1:0] mem_addr, mem_wdata, mem_rdata, cdb_data;
  logic [TW-1:0] cdb_tag;
  logic [NLD*TW-1:0] ld_tag;
  logic [NLD*XL-1:0] ld_addr;
  logic [NST*XL-1:0] st_addr, st_data;
  logic [XL-1:0] mem[256], mm[256];
  bit mem_v[256], mm_v[256];
  int total = 0, bad = 0;
  int cyc = 0, free_at = 0, rr = 0, starve = 0, p_start = 0;
  bit pend = 0;
  logic [XL-1:0] p_addr, p_data;
  logic [TW-1:0] p_tag;
  bit [1:0] e_ld[16], e_st[16];
  bit e_we[16];
  logic [XL-1:0] e_a[16], e_d[16];

  assign ld_tag = {lt[1], lt[0]};
  assign ld_addr = {la[1], la[0]};
  assign st_addr = {sa[1], sa[0]};
  assign st_data = {sd[1], sd[0]};

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return a == 8'h10 ? 32'hDEADBEEF : {24'hA5A5A5, a};
  endfunction

  assign mem_rdata = mem_v[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  always @(posedge clk)
    if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      mem_v[mem_addr[7:0]] <= 1'b1;
    end

  always #5 clk = ~clk;

  mem_access_arbiter #(.NUM_LD(NLD), .NUM_ST(NST), .TAG_W(TW), .XLEN(XL), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_tag(ld_tag), .ld_addr(ld_addr), .ld_ack(ld_ack),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cdb_req(cdb_req),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant), .busy(busy));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // one clock; one-shot requesters drop their request the cycle after the ack
  task automatic step();
    logic [NLD-1:0] a;
    logic [NST-1:0] b;
    @(negedge clk);
    a = ld_ack;
    b = st_ack;
    @(posedge clk);
    #1;
    ld_req = ld_req & ~(a & ld_os);
    st_req = st_req & ~(b & st_os);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  // model: schedules each granted transaction's output events on a cycle timeline
  always @(negedge clk) begin
    int s, j;
    bit ld_any, st_any, exp_req, exp_busy;
    if (!rst_n) begin
      chk("rst_acks", {ld_ack, st_ack}, 0);
      chk("rst_we_req_busy", {mem_we, cdb_req, busy}, 0);
      pend = 0;
      free_at = 0;
      rr = 0;
      starve = 0;
      for (int k = 0; k < 16; k++) begin
        e_ld[k] = 0;
        e_st[k] = 0;
        e_we[k] = 0;
      end
    end else begin
      s = cyc % 16;
      exp_req = pend && cyc >= p_start;
      exp_busy = cyc < free_at || pend;
      chk("ld_ack", ld_ack, e_ld[s]);
      chk("st_ack", st_ack, e_st[s]);
      chk("mem_we", mem_we, e_we[s]);
      if (e_we[s]) begin
        chk("wr_addr", mem_addr, e_a[s]);
        chk("wr_data", mem_wdata, e_d[s]);
      end
      if (pend && cyc < p_start) chk("rd_addr", mem_addr, p_addr);
      chk("cdb_req", cdb_req, exp_req);
      if (exp_req) begin
        chk("cdb_tag", cdb_tag, p_tag);
        chk("cdb_data", cdb_data, p_data);
      end
      chk("busy", busy, exp_busy);
      e_ld[s] = 0;
      e_st[s] = 0;
      e_we[s] = 0;
      ld_any = |ld_req;
      st_any = |st_req;
      if (!ld_any) starve = 0;
      if (exp_req && cdb_grant) begin
        pend = 0;
        free_at = cyc + 1;
      end else if (!pend && cyc >= free_at) begin
        if (ld_any && (starve == SMAX || !st_any)) begin
          j = -1;
          for (int k = 0; k < NLD; k++) if (j < 0 && ld_req[(rr + k) % NLD]) j = (rr + k) % NLD;
          e_ld[(cyc + 1) % 16] = 2'b01 << j;
          pend = 1;
          p_start = cyc + 1 + LAT;
          p_addr = la[j];
          p_tag = lt[j];
          p_data = mm_v[la[j][7:0]] ? mm[la[j][7:0]] : init_val(la[j][7:0]);
          rr = (j + 1) % NLD;
          starve = 0;
        end else if (st_any) begin
          j = -1;
          for (int k = 0; k < NST; k++) if (j < 0 && st_req[k]) j = k;
          e_st[(cyc + 1) % 16] = 2'b01 << j;
          e_we[(cyc + 1) % 16] = 1;
          e_a[(cyc + 1) % 16] = sa[j];
          e_d[(cyc + 1) % 16] = sd[j];
          mm[sa[j][7:0]] = sd[j];
          mm_v[sa[j][7:0]] = 1;
          free_at = cyc + 2;
          if (ld_any && starve < SMAX) starve++;
        end
      end
    end
    cyc++;
  end

  initial begin
    logic [1:0] ord[$];
    int n_st, k;
    for (int i = 0; i < 2; i++) begin
      lt[i] = '0;
      la[i] = '0;
      sa[i] = '0;
      sd[i] = '0;
    end
    ld_os = '0;
    st_os = '0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_cdb_req", cdb_req, 0);
    rst_n = 1;
    step();
    lt[0] = 4'h3; la[0] = 32'h10; ld_os[0] = 1; ld_req[0] = 1;
    step();
    chk("t1_ld_ack", ld_ack, 2'b01);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_req_c1", cdb_req, 0);
    step();
    chk("t1_cdb_req", cdb_req, 1);
    chk("t1_tag", cdb_tag, 4'h3);
    chk("t1_data", cdb_data, 32'hDEADBEEF);
    step();
    chk("t1_cdb_drop", cdb_req, 0);
    sa[0] = 32'h20; sd[0] = 32'h55; st_os[0] = 1; st_req[0] = 1;
    lt[1] = 4'h5; la[1] = 32'h20; ld_os[1] = 1; ld_req[1] = 1;
    step();
    chk("t2_st_ack", st_ack, 2'b01);
    chk("t2_we", mem_we, 1);
    chk("t2_ld_ack_c1", ld_ack, 0);
    step();
    step();
    chk("t2_ld_ack", ld_ack, 2'b10);
    step();
    chk("t2_cdb_data", cdb_data, 32'h55);
    chk("t2_cdb_tag", cdb_tag, 4'h5);
    step();
    ld_os = '0; lt[0] = 4'h1; la[0] = 32'h30; lt[1] = 4'h2; la[1] = 32'h34; ld_req = 2'b11;
    repeat (12) begin
      step();
      if (ld_ack != 0) ord.push_back(ld_ack);
    end
    ld_req = '0;
    chk("t3_count", ord.size(), 4);
    for (int i = 0; i < 4 && i < ord.size(); i++) chk($sformatf("t3_gnt%0d", i), ord[i], i % 2 ? 2'b10 : 2'b01);
    wait_idle();
    cdb_grant = 0; lt[0] = 4'h7; la[0] = 32'h40; ld_os[0] = 1; ld_req = 2'b01;
    step();
    step();
    sa[1] = 32'h44; sd[1] = 32'h99; st_os[1] = 1; st_req[1] = 1;
    repeat (5) begin
      chk("t4_hold_req", cdb_req, 1);
      chk("t4_hold_tag", cdb_tag, 4'h7);
      chk("t4_hold_data", cdb_data, 32'hA5A5A540);
      chk("t4_no_acks", {ld_ack, st_ack}, 0);
      step();
    end
    cdb_grant = 1;
    chk("t4_req_grant_cycle", cdb_req, 1);
    step();
    chk("t4_released", cdb_req, 0);
    chk("t4_idle", busy, 0);
    step();
    chk("t4_st_ack", st_ack, 2'b10);
    step();
    sa[0] = 32'h50; sd[0] = 32'h11; sa[1] = 32'h54; sd[1] = 32'h22; st_os = '0; st_req = 2'b11;
    ld_os = '0; lt[0] = 4'h9; la[0] = 32'h60; ld_req = 2'b01;
    n_st = 0;
    k = 0;
    while (ld_ack == 0 && k < 20) begin
      if (st_ack != 0) n_st++;
      step();
      k++;
    end
    chk("t5_stores_before_load", n_st, 4);
    chk("t5_ld_ack", ld_ack, 2'b01);
    chk("t5_load_cycle", k, 9);
    ld_req = '0;
    st_req = '0;
    wait_idle();
    lt[1] = 4'hA; la[1] = 32'h70; ld_os[1] = 1; ld_req = 2'b10;
    step();
    chk("t6_ld_ack", ld_ack, 2'b10);
    #2;
    rst_n = 0;
    ld_req = '0;
    #1;
    chk("t6_async_ack", ld_ack, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_addr", mem_addr, 0);
    step();
    step();
    rst_n = 1;
    repeat (4) begin
      step();
      chk("t6_no_cdb", cdb_req, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
